// File: rtl/arbitro_fila_prioridade.sv
// rtl/arbitro_fila_prioridade.sv - two-interface priority arbiter with wait FIFO and bounded grants
module arbitro_fila_prioridade #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4,
  parameter int CW          = 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req0_i,
  input  logic [2:0]    user0_i,
  input  logic          req1_i,
  input  logic [2:0]    user1_i,
  input  logic          release_i,
  output logic          grant_valid_o,
  output logic          grant_if_o,
  output logic [2:0]    grant_user_o,
  output logic          done_o,
  output logic [CW-1:0] queue_count_o,
  output logic          queue_full_o,
  output logic          drop_o,
  output logic          err_invalid_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {LIVRE, OCUPADO} state_t;

  function automatic logic code_ok(input logic [2:0] u);
    return !(u == 3'b010 || u == 3'b100 || u == 3'b111);
  endfunction

  // Larger value wins; invalid codes are filtered before they are compared.
  function automatic logic [2:0] rank(input logic [2:0] u);
    case (u)
      3'b101:  return 3'd4;
      3'b011:  return 3'd3;
      3'b001:  return 3'd2;
      3'b110:  return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  state_t          state_q;
  logic [HW-1:0]   hold_q;
  logic            grant_valid_q;
  logic            grant_if_q;
  logic [2:0]      grant_user_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic            drop_q;
  logic            err_q;
  logic [3:0]      mem_q [DEPTH];

  logic            v0, v1, win1;
  logic [3:0]      win_entry, lose_entry, push_e0, push_e1;
  logic            last, pop, grant_new;
  logic [1:0]      want, push_n;
  logic [CW-1:0]   free, count_d;
  logic [AW-1:0]   wr_ptr_d, rd_ptr_d;
  logic            drop_d, err_d;

  always_comb begin
    v0         = req0_i && code_ok(user0_i);
    v1         = req1_i && code_ok(user1_i);
    err_d      = (req0_i && !code_ok(user0_i)) || (req1_i && !code_ok(user1_i));
    win1       = v1 && (!v0 || (rank(user1_i) > rank(user0_i)));
    win_entry  = win1 ? {1'b1, user1_i} : {1'b0, user0_i};
    lose_entry = win1 ? {1'b0, user0_i} : {1'b1, user1_i};
    last       = (state_q == OCUPADO) && ((hold_q == '0) || release_i);
    pop        = (state_q == LIVRE) && (count_q != '0);
    grant_new  = (state_q == LIVRE) && (count_q == '0) && (v0 || v1);
    // The fresh winner bypasses the queue only when nothing is waiting.
    push_e0    = grant_new ? lose_entry : win_entry;
    push_e1    = lose_entry;
    if (grant_new) begin
      want = {1'b0, v0 && v1};
    end else begin
      want = {1'b0, v0} + {1'b0, v1};
    end
    free     = CW'(DEPTH) - count_q + CW'(pop);
    push_n   = (free >= CW'(want)) ? want : free[1:0];
    drop_d   = (want != push_n);
    count_d  = count_q + CW'(push_n) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (push_n != 2'd0) mem_q[wr_ptr_q] <= push_e0;
      if (push_n == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= push_e1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= LIVRE;
      hold_q        <= '0;
      grant_valid_q <= 1'b0;
      grant_if_q    <= 1'b0;
      grant_user_q  <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drop_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      drop_q   <= drop_d;
      err_q    <= err_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        LIVRE: begin
          if (pop || grant_new) begin
            state_q                    <= OCUPADO;
            grant_valid_q              <= 1'b1;
            {grant_if_q, grant_user_q} <= pop ? mem_q[rd_ptr_q] : win_entry;
            hold_q                     <= HW'(HOLD_CYCLES - 1);
          end
        end
        OCUPADO: begin
          if (last) begin
            state_q       <= LIVRE;
            grant_valid_q <= 1'b0;
            grant_if_q    <= 1'b0;
            grant_user_q  <= '0;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
      endcase
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_if_o    = grant_if_q;
  assign grant_user_o  = grant_user_q;
  assign done_o        = last;
  assign queue_count_o = count_q;
  assign queue_full_o  = (count_q == CW'(DEPTH));
  assign drop_o        = drop_q;
  assign err_invalid_o = err_q;
endmodule
